// File: rtl/bfp_block_norm_pkg.sv
// Shared definitions for the block-floating-point normaliser: defaults,
// FSM state encoding and the redundant-sign (leading-sign) count helper.
package bfp_block_norm_pkg;

    localparam int DEPTH_DEF = 8;
    localparam int W_DEF     = 7;
    localparam int SW_DEF    = 3;

    // Legacy-compatible state constants; the enum below is built on them.
    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_REPLAY  = 1'b1;

    typedef enum logic [0:0] {
        STATE_COLLECT = ST_COLLECT,
        STATE_REPLAY  = ST_REPLAY
    } state_e;

    // Redundant sign bits of a w-bit value that has been sign-extended to 32
    // bits: count of leading bits equal to the sign bit, minus one.
    // Result range is 0..w-1.
    function automatic int lrs_count(input logic [31:0] v, input int w);
        int   n;
        logic run;
        n   = 0;
        run = 1'b1;
        for (int i = 30; i >= 0; i--) begin
            if ((i < w - 1) && run) begin
                if (v[i[4:0]] == v[31]) begin
                    n++;
                end else begin
                    run = 1'b0;
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bfp_block_norm_lrs.sv
// Combinational leading-sign counter: how far a sample can be shifted left
// without changing its value.
module bfp_lrs_count
    import bfp_block_norm_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int SW = SW_DEF
) (
    input  logic [W-1:0]  data_i,
    output logic [SW-1:0] lrs_o
);

    logic [31:0] data_ext;

    // Sign-extend so the helper only has to compare against bit 31.
    always_comb begin
        data_ext = 32'($signed(data_i));
        lrs_o    = SW'(lrs_count(data_ext, W));
    end

endmodule

// File: rtl/bfp_block_norm.sv
// Block-floating-point normaliser front end. Collects DEPTH samples while
// tracking the smallest redundant-sign count, then replays the block
// unmodified together with that common shift.
//
// Handshake: a transfer happens on a rising clk_i edge where valid and
// ready are both high; valid-side data is held stable while ready is low.
module bfp_block_norm
    import bfp_block_norm_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W     = W_DEF,
    parameter int SW    = SW_DEF
) (
    input  logic          clk_i,
    input  logic          rst,
    input  logic          in_valid_i,
    input  logic [W-1:0]  in_data_i,
    output logic          in_ready_o,
    output logic          out_valid_o,
    output logic [W-1:0]  out_data_o,
    output logic [SW-1:0] out_shift_o,
    output logic          out_last_o,
    input  logic          out_ready_i,
    output logic          dbg_state_o
);

    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [SW-1:0] blk_shift_q, blk_shift_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  buf_q [DEPTH];

    logic [SW-1:0] sample_lrs;
    logic          accept;
    logic          xfer;

    bfp_lrs_count #(
        .W  (W),
        .SW (SW)
    ) u_lrs (
        .data_i (in_data_i),
        .lrs_o  (sample_lrs)
    );

    assign accept = in_ready_q & in_valid_i;
    assign xfer   = out_valid_q & out_ready_i;

    // Next-state logic: collect/min-track in COLLECT, advance read pointer in REPLAY.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        blk_shift_d = blk_shift_q;
        case (state_q)
            STATE_COLLECT: begin
                if (accept) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    // First sample of a block loads directly; later ones take the minimum.
                    if ((wr_ptr_q == '0) || (sample_lrs < blk_shift_q)) begin
                        blk_shift_d = sample_lrs;
                    end
                    if (wr_ptr_q == LAST_IDX) begin
                        state_d  = STATE_REPLAY;
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                    end
                end
            end
            STATE_REPLAY: begin
                if (xfer) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    if (rd_ptr_q == LAST_IDX) begin
                        state_d  = STATE_COLLECT;
                        rd_ptr_d = '0;
                        wr_ptr_d = '0;
                    end
                end
            end
            default: begin
                state_d = STATE_COLLECT;
            end
        endcase
        // Handshake flags follow the state being entered, giving 1-cycle latency.
        in_ready_d  = (state_d == STATE_COLLECT);
        out_valid_d = (state_d == STATE_REPLAY);
    end

    // Control state registers; reset discards any partial block at once.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state_q     <= STATE_COLLECT;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            blk_shift_q <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            blk_shift_q <= blk_shift_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Sample buffer: plain register array, contents survive reset.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            buf_q[wr_ptr_q] <= in_data_i;
        end
    end

    // Outputs are forced to zero whenever nothing valid is presented.
    always_comb begin
        in_ready_o  = in_ready_q;
        out_valid_o = out_valid_q;
        out_data_o  = out_valid_q ? buf_q[rd_ptr_q] : '0;
        out_shift_o = out_valid_q ? blk_shift_q : '0;
        out_last_o  = out_valid_q && (rd_ptr_q == LAST_IDX);
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_bfp_block_norm.sv
// Self-checking bench for bfp_block_norm: a queue-based block model is
// compared against the DUT on every falling edge, plus directed blocks with
// hand-computed shift values and randomized blocks/backpressure.
module tb_bfp_block_norm;

    localparam int DEPTH = 8;
    localparam int W     = 7;
    localparam int SW    = 3;
    localparam int LIMIT = 300;

    // ---------------- clock / reset ----------------
    logic          clk_i = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid_i = 1'b0;
    logic [W-1:0]  in_data_i = '0;
    logic          out_ready_i = 1'b1;
    logic          in_ready_o;
    logic          out_valid_o;
    logic [W-1:0]  out_data_o;
    logic [SW-1:0] out_shift_o;
    logic          out_last_o;
    logic          dbg_state_o;

    always #5 clk_i = ~clk_i;

    bfp_block_norm #(
        .DEPTH (DEPTH),
        .W     (W),
        .SW    (SW)
    ) dut (
        .clk_i       (clk_i),
        .rst         (rst),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_shift_o (out_shift_o),
        .out_last_o  (out_last_o),
        .out_ready_i (out_ready_i),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- counters ----------------
    int n_vec = 0;
    int n_bad = 0;
    int last_shift_seen = -1;
    int dut_xfers = 0;
    int rdy_rand = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Smallest-magnitude view: lrs is the largest k such that x still fits in
    // a signed field of W-k bits.
    function automatic int m_lrs(input int x);
        for (int k = W - 1; k >= 0; k--) begin
            if ((x >= -(1 << (W - 1 - k))) && (x < (1 << (W - 1 - k)))) return k;
        end
        return -1;
    endfunction

    int   q_coll[$];
    int   q_rep[$];
    int   m_shift = 0;
    logic m_in_ready = 1'b0;
    logic m_out_valid = 1'b0;

    // Compare on the falling edge, then advance the model to the next rising edge.
    always @(negedge clk_i) begin
        int   e_data;
        int   e_shift;
        int   e_last;
        int   mn;
        if (rst) begin
            q_coll.delete();
            q_rep.delete();
            m_in_ready  = 1'b0;
            m_out_valid = 1'b0;
        end
        e_data  = m_out_valid ? q_rep[0] : 0;
        e_shift = m_out_valid ? m_shift : 0;
        e_last  = (m_out_valid && q_rep.size() == 1) ? 1 : 0;
        check("in_ready",  int'(in_ready_o),  int'(m_in_ready));
        check("out_valid", int'(out_valid_o), int'(m_out_valid));
        check("out_data",  int'($signed(out_data_o)), e_data);
        check("out_shift", int'(out_shift_o), e_shift);
        check("out_last",  int'(out_last_o),  e_last);
        if (out_valid_o) last_shift_seen = int'(out_shift_o);
        if (out_valid_o && out_ready_i && !rst) dut_xfers++;
        if (!rst) begin
            if (m_out_valid && out_ready_i) void'(q_rep.pop_front());
            if (m_in_ready && in_valid_i) begin
                q_coll.push_back(int'($signed(in_data_i)));
                if (q_coll.size() == DEPTH) begin
                    mn = W - 1;
                    foreach (q_coll[i]) if (m_lrs(q_coll[i]) < mn) mn = m_lrs(q_coll[i]);
                    m_shift = mn;
                    q_rep   = q_coll;
                    q_coll.delete();
                end
            end
            m_in_ready  = (q_rep.size() == 0);
            m_out_valid = (q_rep.size() != 0);
        end
    end

    // ---------------- drivers ----------------
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            out_ready_i = (rdy_rand != 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    task automatic push_sample(input int v);
        int t;
        in_valid_i = 1'b1;
        in_data_i  = W'(v);
        t = 0;
        @(negedge clk_i);
        while (!in_ready_o && t < LIMIT) begin
            t++;
            @(negedge clk_i);
        end
        if (t >= LIMIT) check("accept_timeout", 0, 1);
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_block(input int b[DEPTH]);
        for (int i = 0; i < DEPTH; i++) push_sample(b[i]);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        @(negedge clk_i);
        while (!(in_ready_o && !out_valid_o) && t < LIMIT) begin
            t++;
            @(negedge clk_i);
        end
        if (t >= LIMIT) check("drain_timeout", 0, 1);
    endtask

    function automatic int rand_sample();
        int k;
        int span;
        k    = $urandom_range(0, W - 1);
        span = 1 << k;
        return int'($urandom_range(0, 2 * span - 1)) - span;
    endfunction

    // ---------------- stimulus ----------------
    int blk[DEPTH];
    int x0;

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        rst = 1'b0;

        // Pin the model's lrs against hand-counted values (3 = 0000011 -> 4).
        check("lrs_0",   m_lrs(0),   6);
        check("lrs_m1",  m_lrs(-1),  6);
        check("lrs_3",   m_lrs(3),   4);
        check("lrs_m4",  m_lrs(-4),  4);
        check("lrs_63",  m_lrs(63),  0);
        check("lrs_m64", m_lrs(-64), 0);
        check("lrs_1",   m_lrs(1),   5);

        // Mixed small block, full-speed drain.
        blk = '{3, -4, 1, 0, 2, -1, 1, 0};
        x0 = dut_xfers;
        send_block(blk);
        in_valid_i = 1'b0;
        wait_drain();
        check("mixed_shift", last_shift_seen, 4);
        check("mixed_xfers", dut_xfers - x0, DEPTH);

        // Extremes.
        blk = '{1, 2, 63, 0, -1, 4, 5, 6};
        send_block(blk);
        in_valid_i = 1'b0;
        wait_drain();
        check("max_pos_shift", last_shift_seen, 0);
        blk = '{0, 0, 0, -64, 0, 0, 0, 0};
        send_block(blk);
        in_valid_i = 1'b0;
        wait_drain();
        check("max_neg_shift", last_shift_seen, 0);
        blk = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_block(blk);
        in_valid_i = 1'b0;
        wait_drain();
        check("zero_shift", last_shift_seen, 6);

        // Random backpressure during replay.
        rdy_rand = 1;
        for (int i = 0; i < DEPTH; i++) blk[i] = rand_sample();
        x0 = dut_xfers;
        send_block(blk);
        in_valid_i = 1'b0;
        wait_drain();
        check("stall_xfers", dut_xfers - x0, DEPTH);
        rdy_rand = 0;

        // Back-to-back blocks with in_valid held high through replay.
        blk = '{63, 0, 0, 0, 0, 0, 0, 0};
        send_block(blk);
        blk = '{1, 1, 1, 1, 1, 1, 1, 1};
        send_block(blk);
        in_valid_i = 1'b0;
        wait_drain();
        check("b2b_second_shift", last_shift_seen, 5);

        // Reset mid-collect discards the partial block.
        for (int i = 0; i < 5; i++) push_sample(40);
        in_valid_i = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst = 1'b0;
        blk = '{1, 1, 1, 1, 1, 1, 1, 1};
        x0 = dut_xfers;
        send_block(blk);
        in_valid_i = 1'b0;
        wait_drain();
        check("post_rst_shift", last_shift_seen, 5);
        check("post_rst_xfers", dut_xfers - x0, DEPTH);

        // Randomized blocks with random backpressure and idle gaps.
        for (int b = 0; b < 20; b++) begin
            rdy_rand = $urandom_range(0, 1);
            for (int i = 0; i < DEPTH; i++) blk[i] = rand_sample();
            send_block(blk);
            if ($urandom_range(0, 1) == 1) in_valid_i = 1'b0;
        end
        in_valid_i = 1'b0;
        rdy_rand = 0;
        wait_drain();

        repeat (2) @(posedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
